mac_sequencer: RTL and testbench
================================

Name: mac_sequencer

Overview:
Control-side counterpart of the fixed-point MAC logical unit: drives its mem/data/add_bias/sum_en/reset inputs and collects its result. Accepts one input activation vector over a valid/ready stream and buffers it. For each output neuron it issues weight and bias reads to a synchronous weight ROM and feeds the matching activations to the MAC. It returns each neuron's saturated weighted sum on a valid/ready output stream. Sits between the previous layer's output stream and one MAC instance inside a dense/conv layer.

Parameters:
WORD_SIZE, 16, width of activations, weights and results (fixed point, matches MAC)
N_IN, 8, activations per input vector (weights per neuron)
N_OUT, 4, output neurons computed sequentially per input vector
ADDR_W, $clog2(N_OUT*(N_IN+1)), weight ROM address width (derived)

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
valid_i  in  1  input activation valid
ready_o  out  1  input activation accepted when valid_i && ready_o
data_i  in  WORD_SIZE  input activation, signed
mem_addr_o  out  ADDR_W  weight ROM address; ROM data reaches MAC mem_i one cycle later
mem_rd_o  out  1  ROM read enable
mac_clear_o  out  1  drives MAC reset_i (clears accumulator)
mac_data_o  out  WORD_SIZE  drives MAC data_i
mac_sum_en_o  out  1  drives MAC sum_en
mac_add_bias_o  out  1  drives MAC add_bias
mac_result_i  in  WORD_SIZE  MAC data_o
valid_o  out  1  result valid
ready_i  in  1  downstream ready
data_o  out  WORD_SIZE  neuron result, signed
last_o  out  1  high with valid_o for neuron N_OUT-1

Behaviour:
- Reset (async): state=IDLE; counters 0; all outputs 0. IDLE -> LOAD on first edge after release; ready_o=1 from that cycle.
- ROM layout: neuron n at base n*(N_IN+1); offsets 0..N_IN-1 weights, offset N_IN bias.
- LOAD: ready_o=1; each handshake writes data_i to buffer[in_cnt] and increments in_cnt. Handshake with in_cnt==N_IN-1 -> CLEAR, ready_o=0, in_cnt=0.
- CLEAR (1 cycle): mac_clear_o=1 -> ISSUE, issue_cnt=0.
- ISSUE (N_IN+1 cycles): mem_rd_o=1, mem_addr_o=base+issue_cnt. Stage register, one cycle later: mac_sum_en_o=1, mac_data_o=buffer[issue_cnt] (0 for bias), mac_add_bias_o=(issue_cnt==N_IN). Last issue -> DRAIN.
- DRAIN (2 cycles): cycle 0 carries last staged sum_en (bias add); cycle 1 captures mac_result_i into result register -> OUTPUT.
- OUTPUT: valid_o=1, data_o=result, last_o=(neuron==N_OUT-1); held stable until ready_i. On handshake: non-last -> CLEAR with neuron+1; last -> LOAD with neuron=0, ready_o=1 next cycle.
- Per-neuron latency from CLEAR entry to valid_o: N_IN+4 cycles. No mem_rd_o or mac_sum_en_o outside ISSUE/DRAIN0; outputs hold under backpressure.
- valid_i ignored outside LOAD. No input prefetch during compute.
- Saturation is the MAC's job; the result passes through unmodified.
- Reset mid-operation: everything aborts to IDLE; partial vector and result discarded; mac_clear_o=0 during reset (MAC shares reset_i).

Decomposition:
- Package mac_seq_pkg: state enum {IDLE, LOAD, CLEAR, ISSUE, DRAIN, OUTPUT}; address/count width functions.
- Sub-module activation_buffer: N_IN x WORD_SIZE register file, 1 write port (index, enable), 1 combinational read port.

Test Plan (WORD_SIZE=16, INT_BITS=8, N_IN=2, N_OUT=2, real MAC + 1-cycle ROM):
- Inputs 0x0100,0x0200; ROM[0..2]=0x0080,0x0040,0x0100 -> data_o=0x0200 neuron 0; addresses 0,1,2 then 3,4,5.
- ROM[3..5]=0x7F00,0x7F00,0x0000 -> neuron 1 data_o=0x7FFF (saturated), last_o=1; ready_o=1 next cycle.
- ready_i held low 5 cycles in OUTPUT -> valid_o/data_o stable, mem_rd_o=0, no sum_en pulses.
- valid_i toggled 1/0 during LOAD and asserted during ISSUE -> only LOAD handshakes counted; buffer holds exactly 2 words.
- reset_i asserted mid-ISSUE -> all outputs 0 immediately; after release, fresh vector yields 0x0200 again.
- Cycle check: CLEAR entry to valid_o = 6 cycles; mac_add_bias_o high exactly once per neuron, coincident with bias ROM data.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// Shared types and width helpers for the MAC sequencer slice.
package mac_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLEAR,
        ISSUE,
        DRAIN,
        OUTPUT
    } state_t;

    // Width of a counter that must hold values 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int addr_width(input int n_in, input int n_out);
        return cnt_width(n_out * (n_in + 1));
    endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Activation stream, weight ROM, MAC control and result stream of the MAC sequencer.
interface mac_sequencer_if #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_W    = 6
);
    logic                 valid_i;
    logic                 ready_o;
    logic [WORD_SIZE-1:0] data_i;
    logic [ADDR_W-1:0]    mem_addr_o;
    logic                 mem_rd_o;
    logic                 mac_clear_o;
    logic [WORD_SIZE-1:0] mac_data_o;
    logic                 mac_sum_en_o;
    logic                 mac_add_bias_o;
    logic [WORD_SIZE-1:0] mac_result_i;
    logic                 valid_o;
    logic                 ready_i;
    logic [WORD_SIZE-1:0] data_o;
    logic                 last_o;

    modport slave (
        input  valid_i, data_i, mac_result_i, ready_i,
        output ready_o, mem_addr_o, mem_rd_o, mac_clear_o, mac_data_o,
               mac_sum_en_o, mac_add_bias_o, valid_o, data_o, last_o
    );

    modport master (
        output valid_i, data_i, mac_result_i, ready_i,
        input  ready_o, mem_addr_o, mem_rd_o, mac_clear_o, mac_data_o,
               mac_sum_en_o, mac_add_bias_o, valid_o, data_o, last_o
    );
endinterface

// File: rtl/activation_buffer.sv
// N_IN-entry activation register file: one synchronous write port, one combinational read port.
module activation_buffer #(
    parameter int WORD_SIZE = 16,
    parameter int N_IN      = 8,
    parameter int IDX_W     = 3
) (
    input  logic                 clk_i,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [WORD_SIZE-1:0] rd_data
);
    logic [WORD_SIZE-1:0] mem [N_IN];

    // NOTE: storage has no reset; every entry is rewritten by a full vector before any read uses it.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/mac_sequencer.sv
// Buffers one activation vector, then walks each neuron's weights and bias through a MAC.
module mac_sequencer
    import mac_seq_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int N_IN      = 8,
    parameter int N_OUT     = 4
) (
    input  logic           clk_i,
    input  logic           reset_i,
    mac_sequencer_if.slave bus
);
    localparam int ADDR_W = addr_width(N_IN, N_OUT);
    localparam int IN_W   = cnt_width(N_IN);
    localparam int ISS_W  = cnt_width(N_IN + 1);
    localparam int NEU_W  = cnt_width(N_OUT);

    localparam logic [IN_W-1:0]   IN_LAST  = IN_W'(N_IN - 1);
    localparam logic [ISS_W-1:0]  ISS_LAST = ISS_W'(N_IN);
    localparam logic [NEU_W-1:0]  NEU_LAST = NEU_W'(N_OUT - 1);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(N_IN + 1);

    state_t               state, state_next;
    logic [IN_W-1:0]      in_cnt;
    logic [ISS_W-1:0]     issue_cnt;
    logic [NEU_W-1:0]     neuron;
    logic [ADDR_W-1:0]    base;
    logic                 drain_cnt;
    logic                 stage_sum_en;
    logic                 stage_bias;
    logic [WORD_SIZE-1:0] stage_data;
    logic [WORD_SIZE-1:0] result;
    logic [WORD_SIZE-1:0] buf_rd_data;

    logic ready, mem_rd, clear, valid;
    logic in_fire, in_last, issue_last, neuron_last;

    assign in_fire     = (state == LOAD) && bus.valid_i;
    assign in_last     = (in_cnt == IN_LAST);
    assign issue_last  = (issue_cnt == ISS_LAST);
    assign neuron_last = (neuron == NEU_LAST);

    activation_buffer #(
        .WORD_SIZE (WORD_SIZE),
        .N_IN      (N_IN),
        .IDX_W     (IN_W)
    ) u_buf (
        .clk_i   (clk_i),
        .wr_en   (in_fire),
        .wr_idx  (in_cnt),
        .wr_data (bus.data_i),
        .rd_idx  (issue_cnt[IN_W-1:0]),
        .rd_data (buf_rd_data)
    );

    // NOTE: every output is given a default before the case, so no path can infer a latch.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        mem_rd     = 1'b0;
        clear      = 1'b0;
        valid      = 1'b0;
        unique case (state)
            IDLE:   state_next = LOAD;
            LOAD: begin
                ready = 1'b1;
                if (in_fire && in_last) state_next = CLEAR;
            end
            CLEAR: begin
                clear      = 1'b1;
                state_next = ISSUE;
            end
            ISSUE: begin
                mem_rd = 1'b1;
                if (issue_last) state_next = DRAIN;
            end
            DRAIN:  if (drain_cnt) state_next = OUTPUT;
            OUTPUT: begin
                valid = 1'b1;
                if (bus.ready_i) state_next = neuron_last ? LOAD : CLEAR;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state        <= IDLE;
            in_cnt       <= '0;
            issue_cnt    <= '0;
            neuron       <= '0;
            base         <= '0;
            drain_cnt    <= 1'b0;
            stage_sum_en <= 1'b0;
            stage_bias   <= 1'b0;
            stage_data   <= '0;
            result       <= '0;
        end else begin
            state <= state_next;

            // The stage lines up activation and control with the ROM's one-cycle read latency.
            stage_sum_en <= (state == ISSUE);
            stage_bias   <= (state == ISSUE) && issue_last;
            stage_data   <= ((state == ISSUE) && !issue_last) ? buf_rd_data : '0;

            unique case (state)
                LOAD: if (in_fire) in_cnt <= in_last ? '0 : in_cnt + IN_W'(1);
                CLEAR: begin
                    issue_cnt <= '0;
                    drain_cnt <= 1'b0;
                end
                ISSUE: if (!issue_last) issue_cnt <= issue_cnt + ISS_W'(1);
                DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) result <= bus.mac_result_i;
                end
                OUTPUT: begin
                    if (bus.ready_i) begin
                        neuron <= neuron_last ? '0 : neuron + NEU_W'(1);
                        base   <= neuron_last ? '0 : base + STRIDE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready_o        = ready;
    assign bus.mem_rd_o       = mem_rd;
    assign bus.mem_addr_o     = mem_rd ? base + ADDR_W'(issue_cnt) : '0;
    assign bus.mac_clear_o    = clear;
    assign bus.mac_sum_en_o   = stage_sum_en;
    assign bus.mac_add_bias_o = stage_bias;
    assign bus.mac_data_o     = stage_data;
    assign bus.valid_o        = valid;
    assign bus.data_o         = result;
    assign bus.last_o         = valid && neuron_last;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench: mac_sequencer with a 1-cycle weight ROM and a Q8.8 saturating MAC model.
module tb_mac_sequencer;
    import mac_seq_pkg::*;

    localparam int WS    = 16;
    localparam int N_IN  = 2;
    localparam int N_OUT = 2;
    localparam int AW    = addr_width(N_IN, N_OUT);
    localparam int ROM_N = N_OUT * (N_IN + 1);
    localparam int LAT   = N_IN + 4;

    typedef struct packed {
        logic [N_IN-1:0][WS-1:0]  x;
        logic [ROM_N-1:0][WS-1:0] w;
        logic [N_OUT-1:0][WS-1:0] want;
        int                       bp;
        bit                       toggle;
    } vec_t;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;

    mac_sequencer_if #(.WORD_SIZE(WS), .ADDR_W(AW)) bus ();

    mac_sequencer #(.WORD_SIZE(WS), .N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [WS-1:0] sat16(input longint v);
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    // Reference: saturate(sum of (x*w)>>8 over the neuron's weights, plus bias).
    function automatic logic [WS-1:0] ref_neuron(input logic [N_IN-1:0][WS-1:0] x,
                                                 input logic [ROM_N-1:0][WS-1:0] w,
                                                 input int n);
        longint s = 0;
        for (int k = 0; k < N_IN; k++)
            s += (longint'($signed(x[k])) * longint'($signed(w[n*(N_IN+1)+k]))) >>> 8;
        s += longint'($signed(w[n*(N_IN+1)+N_IN]));
        return sat16(s);
    endfunction

    // Weight ROM (one-cycle read) and fixed-point MAC environment.
    logic [WS-1:0]        rom [1 << AW];
    logic signed [WS-1:0] rom_q      = '0;
    logic                 rom_bias_q = 1'b0;
    longint               acc;

    always @(posedge clk_i) begin
        if (bus.mem_rd_o) begin
            rom_q      <= rom[bus.mem_addr_o];
            rom_bias_q <= (int'(bus.mem_addr_o) % (N_IN + 1)) == N_IN;
        end
    end

    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i)               acc <= 0;
        else if (bus.mac_clear_o)  acc <= 0;
        else if (bus.mac_sum_en_o)
            acc <= acc + (bus.mac_add_bias_o ? longint'(rom_q)
                          : (longint'(rom_q) * longint'($signed(bus.mac_data_o))) >>> 8);
    end

    assign bus.mac_result_i = sat16(acc);

    // Monitor samples mid-cycle, after the stimulus process has driven its inputs.
    int  cyc = 0, hs_cnt = 0, sum_en_cnt = 0, bias_cnt = 0, align_err = 0, last_clear = 0;
    bit  prev_valid = 1'b0;
    int  addr_log[$];
    int  lat_log[$];

    always @(negedge clk_i) begin
        #2;
        cyc <= cyc + 1;
        if (bus.valid_i && bus.ready_o) hs_cnt <= hs_cnt + 1;
        if (bus.mem_rd_o) addr_log.push_back(int'(bus.mem_addr_o));
        if (bus.mac_sum_en_o) sum_en_cnt <= sum_en_cnt + 1;
        if (bus.mac_add_bias_o) bias_cnt <= bias_cnt + 1;
        if ((bus.mac_sum_en_o && (bus.mac_add_bias_o !== rom_bias_q)) ||
            (bus.mac_add_bias_o && !bus.mac_sum_en_o))
            align_err <= align_err + 1;
        if (bus.mac_clear_o) last_clear <= cyc;
        if (bus.valid_o && !prev_valid) lat_log.push_back(cyc - last_clear);
        prev_valid <= bus.valid_o;
    end

    task automatic check_all_zero(input string tag);
        check({tag, " ready_o"},        32'(bus.ready_o), 0);
        check({tag, " mem_rd_o"},       32'(bus.mem_rd_o), 0);
        check({tag, " mem_addr_o"},     32'(bus.mem_addr_o), 0);
        check({tag, " mac_clear_o"},    32'(bus.mac_clear_o), 0);
        check({tag, " mac_sum_en_o"},   32'(bus.mac_sum_en_o), 0);
        check({tag, " mac_add_bias_o"}, 32'(bus.mac_add_bias_o), 0);
        check({tag, " mac_data_o"},     32'(bus.mac_data_o), 0);
        check({tag, " valid_o"},        32'(bus.valid_o), 0);
        check({tag, " data_o"},         32'(bus.data_o), 0);
        check({tag, " last_o"},         32'(bus.last_o), 0);
    endtask

    task automatic load_rom(input logic [ROM_N-1:0][WS-1:0] w);
        for (int i = 0; i < (1 << AW); i++) rom[i] = (i < ROM_N) ? w[i] : '0;
    endtask

    task automatic send_vector(input logic [N_IN-1:0][WS-1:0] x, input bit toggle);
        int n_wait = 0;
        while (!bus.ready_o && n_wait < 20) begin
            @(negedge clk_i);
            n_wait++;
        end
        check("load ready_o", 32'(bus.ready_o), 1);
        for (int k = 0; k < N_IN; k++) begin
            if (toggle && k > 0) begin
                bus.valid_i = 1'b0;
                bus.data_i  = 16'hDEAD;
                @(negedge clk_i);
            end
            bus.valid_i = 1'b1;
            bus.data_i  = x[k];
            @(negedge clk_i);
        end
        if (toggle) begin
            bus.data_i = 16'h5A5A;
            repeat (4) begin
                check("ready_o low during compute", 32'(bus.ready_o), 0);
                @(negedge clk_i);
            end
        end else begin
            check("ready_o low after last word", 32'(bus.ready_o), 0);
        end
        bus.valid_i = 1'b0;
    endtask

    task automatic run_vector(input string tag, input vec_t v);
        int a0 = addr_log.size();
        int l0 = lat_log.size();
        int h0 = hs_cnt, s0 = sum_en_cnt, b0 = bias_cnt, e0 = align_err;
        int n_wait;
        load_rom(v.w);
        send_vector(v.x, v.toggle);
        for (int n = 0; n < N_OUT; n++) begin
            n_wait = 0;
            while (!bus.valid_o && n_wait < 40) begin
                @(negedge clk_i);
                n_wait++;
            end
            check({tag, " valid_o"}, 32'(bus.valid_o), 1);
            for (int i = 0; i < v.bp; i++) begin
                check({tag, " held data_o"}, 32'(bus.data_o), 32'(v.want[n]));
                check({tag, " held valid_o"}, 32'(bus.valid_o), 1);
                check({tag, " held mem_rd_o"}, 32'(bus.mem_rd_o), 0);
                check({tag, " held sum_en"}, 32'(bus.mac_sum_en_o), 0);
                @(negedge clk_i);
            end
            check({tag, " data_o"}, 32'(bus.data_o), 32'(v.want[n]));
            check({tag, " last_o"}, 32'(bus.last_o), (n == N_OUT - 1) ? 1 : 0);
            bus.ready_i = 1'b1;
            @(negedge clk_i);
            bus.ready_i = 1'b0;
            if (n == N_OUT - 1) check({tag, " ready_o after last"}, 32'(bus.ready_o), 1);
            else                check({tag, " clear after output"}, 32'(bus.mac_clear_o), 1);
        end
        check({tag, " rom reads"}, 32'(addr_log.size() - a0), ROM_N);
        if (addr_log.size() - a0 >= ROM_N)
            for (int n = 0; n < N_OUT; n++)
                for (int k = 0; k <= N_IN; k++)
                    check({tag, " rom addr"}, 32'(addr_log[a0 + n*(N_IN+1) + k]), 32'(n*(N_IN+1) + k));
        check({tag, " latency count"}, 32'(lat_log.size() - l0), N_OUT);
        if (lat_log.size() - l0 >= N_OUT)
            for (int n = 0; n < N_OUT; n++)
                check({tag, " clear-to-valid"}, 32'(lat_log[l0 + n]), LAT);
        check({tag, " input handshakes"}, 32'(hs_cnt - h0), N_IN);
        check({tag, " sum_en pulses"}, 32'(sum_en_cnt - s0), N_OUT * (N_IN + 1));
        check({tag, " add_bias pulses"}, 32'(bias_cnt - b0), N_OUT);
        check({tag, " bias alignment"}, 32'(align_err - e0), 0);
    endtask

    function automatic vec_t mk(input logic [WS-1:0] x0, x1, w0, w1, w2, w3, w4, w5, e0, e1,
                                input int bp, input bit toggle);
        vec_t v;
        v.x      = {x1, x0};
        v.w      = {w5, w4, w3, w2, w1, w0};
        v.want   = {e1, e0};
        v.bp     = bp;
        v.toggle = toggle;
        return v;
    endfunction

    vec_t tbl[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        tbl[0] = mk(16'h0100, 16'h0200, 16'h0080, 16'h0040, 16'h0100,
                    16'h7F00, 16'h7F00, 16'h0000, 16'h0200, 16'h7FFF, 0, 1'b0);
        tbl[1] = mk(16'h0100, 16'h0200, 16'h0080, 16'h0040, 16'h0100,
                    16'h7F00, 16'h7F00, 16'h0000, 16'h0200, 16'h7FFF, 5, 1'b1);
        tbl[2] = mk(16'hFF00, 16'h0080, 16'h0100, 16'h0200, 16'h0000,
                    16'h0100, 16'h0100, 16'hFF80, 16'h0000, 16'hFF00, 1, 1'b0);
        tbl[3] = mk(16'h8000, 16'h7FFF, 16'h7F00, 16'h0000, 16'h8000,
                    16'h0100, 16'h0100, 16'h0000, 16'h8000, 16'hFFFF, 2, 1'b1);

        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        bus.ready_i = 1'b0;
        load_rom(tbl[0].w);
        repeat (2) @(negedge clk_i);
        check_all_zero("reset");
        reset_i = 1'b0;
        check("idle ready_o", 32'(bus.ready_o), 0);
        @(negedge clk_i);
        check("ready_o after first edge", 32'(bus.ready_o), 1);

        for (int t = 0; t < 4; t++) run_vector($sformatf("vec%0d", t), tbl[t]);

        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < N_IN; k++)
                v.x[k] = $urandom_range(0, 1) ? WS'($urandom) : WS'($urandom_range(0, 1023)) - 16'd512;
            for (int i = 0; i < ROM_N; i++)
                v.w[i] = $urandom_range(0, 1) ? WS'($urandom) : WS'($urandom_range(0, 1023)) - 16'd512;
            for (int n = 0; n < N_OUT; n++) v.want[n] = ref_neuron(v.x, v.w, n);
            v.bp     = $urandom_range(0, 3);
            v.toggle = 1'($urandom_range(0, 1));
            run_vector($sformatf("rand%0d", r), v);
        end

        // Abort a vector mid-ISSUE with an asynchronous reset, then rerun cleanly.
        load_rom(tbl[0].w);
        send_vector(tbl[0].x, 1'b0);
        for (int i = 0; i < 10 && !bus.mem_rd_o; i++) @(negedge clk_i);
        check("reached ISSUE before reset", 32'(bus.mem_rd_o), 1);
        #2 reset_i = 1'b1;
        #1 check_all_zero("mid-issue reset");
        @(negedge clk_i);
        reset_i = 1'b0;
        run_vector("after reset", tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
